seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 10 +
 rtl/seq_divider_add_sub.sv | 28 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_add_sub.sv
// Ripple-carry adder/subtractor: M=0 computes A+B, M=1 computes A-B.
// On subtraction, CarryOut=1 means no borrow occurred.
module add_sub #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    output logic [W-1:0] Sum,
    output logic         CarryOut
);

    logic [W-1:0] bx;

    assign bx = B ^ {W{M}};

    always_comb begin
        logic carry;
        carry = M;
        Sum   = '0;
        for (int i = 0; i < W; i++) begin
            Sum[i] = A[i] ^ bx[i] ^ carry;
            carry  = (A[i] & bx[i]) | (A[i] & carry) | (bx[i] & carry);
        end
        CarryOut = carry;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per CALC cycle,
// with a single-cycle shortcut for division by zero.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    state_t        state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [N:0]    newRem;
    logic          carryOut;
    logic          noBorrow;

    assign shifted = {rem_q[N-1:0], dvd_q[N-1]};

    add_sub #(
        .W(N + 1)
    ) u_trialSub (
        .A       (shifted),
        .B       ({1'b0, dvs_q}),
        .M       (1'b1),
        .Sum     (diff),
        .CarryOut(carryOut)
    );

    // A set bit shifted out of the top means the value certainly exceeds the divisor.
    assign noBorrow = carryOut | rem_q[N];
    assign newRem   = noBorrow ? diff : shifted;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CW'(N - 1);
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            CALC: begin
                rem_d = newRem;
                dvd_d = {dvd_q[N-2:0], noBorrow};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_d  = {dvd_q[N-2:0], noBorrow};
                    remainder_d = newRem[N-1:0];
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
